// File: rtl/fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO controllers.
// Gray/binary conversion works on a 32-bit container; callers slice their width.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int CONV_W = 32;

  function automatic logic [CONV_W-1:0] bin2gray(
    input logic [CONV_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(
    input logic [CONV_W-1:0] g
  );
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_bus.sv
// Multi-flop synchroniser for a gray-coded bus crossing clock domains.
// Synchronous active-high reset clears every stage.
module fifo_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl_prog.sv
// Read-side FIFO controller: synchronised write pointer, fill level,
// programmable almost-empty flag and sticky underflow error.
module fifo_rd_ctrl_prog
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic                  Rclk,
  input  logic                  Rrst,
  input  logic                  Rinc,
  input  logic [ADDR_WIDTH:0]   Wptr_gray,
  input  logic [ADDR_WIDTH:0]   Rae_thresh,
  input  logic                  Rclr_err,
  output logic [ADDR_WIDTH-1:0] Radder,
  output logic [ADDR_WIDTH:0]   Rptr,
  output logic                  Rempty,
  output logic                  Ralmost_empty,
  output logic [ADDR_WIDTH:0]   Rlevel,
  output logic                  Runderflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wq;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic          rd_en;

  logic [CONV_W-1:0] wbin_full;
  logic [CONV_W-1:0] rgray_full;
  logic              unused_hi;

  fifo_sync_bus #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_wsync (
    .clk(Rclk),
    .rst(Rrst),
    .d  (Wptr_gray),
    .q  (wq)
  );

  assign wbin_full  = gray2bin(CONV_W'(wq));
  assign wbin       = wbin_full[PW-1:0];
  assign rd_en      = Rinc & ~Rempty;
  assign rbin_next  = rbin + PW'(rd_en);
  assign rgray_full = bin2gray(CONV_W'(rbin_next));
  assign rgray_next = rgray_full[PW-1:0];
  assign level_next = wbin - rbin_next;
  assign unused_hi  = ^{wbin_full[CONV_W-1:PW], rgray_full[CONV_W-1:PW]};

  always_ff @(posedge Rclk) begin
    if (Rrst) begin
      rbin          <= '0;
      Rptr          <= '0;
      Rempty        <= 1'b1;
      Ralmost_empty <= 1'b1;
      Rlevel        <= '0;
      Runderflow    <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      Rptr          <= rgray_next;
      Rempty        <= (rgray_next == wq);
      Rlevel        <= level_next;
      Ralmost_empty <= (level_next <= Rae_thresh);
      // a fresh underflow outranks a concurrent clear
      if (Rinc & Rempty) begin
        Runderflow <= 1'b1;
      end else if (Rclr_err) begin
        Runderflow <= 1'b0;
      end
    end
  end

  assign Radder = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl_prog.sv
// Directed bench for fifo_rd_ctrl_prog with ADDR_WIDTH=3, SYNC_STAGES=2.
module tb_fifo_rd_ctrl_prog;

  logic       Rclk = 1'b0;
  logic       Rrst;
  logic       Rinc;
  logic [3:0] Wptr_gray;
  logic [3:0] Rae_thresh;
  logic       Rclr_err;
  logic [2:0] Radder;
  logic [3:0] Rptr;
  logic       Rempty;
  logic       Ralmost_empty;
  logic [3:0] Rlevel;
  logic       Runderflow;

  int n_cmp = 0;
  int n_bad = 0;

  int gexp [0:8] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

  fifo_rd_ctrl_prog #(
    .ADDR_WIDTH (3),
    .SYNC_STAGES(2)
  ) dut (
    .Rclk         (Rclk),
    .Rrst         (Rrst),
    .Rinc         (Rinc),
    .Wptr_gray    (Wptr_gray),
    .Rae_thresh   (Rae_thresh),
    .Rclr_err     (Rclr_err),
    .Radder       (Radder),
    .Rptr         (Rptr),
    .Rempty       (Rempty),
    .Ralmost_empty(Ralmost_empty),
    .Rlevel       (Rlevel),
    .Runderflow   (Runderflow)
  );

  always #5 Rclk = ~Rclk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Rclk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_empty"}, 32'(Rempty), 1);
    check({tag, "_ae"}, 32'(Ralmost_empty), 1);
    check({tag, "_rptr"}, 32'(Rptr), 0);
    check({tag, "_radder"}, 32'(Radder), 0);
    check({tag, "_level"}, 32'(Rlevel), 0);
    check({tag, "_uf"}, 32'(Runderflow), 0);
  endtask

  initial begin
    Rrst = 1'b1;
    Rinc = 1'b0;
    Wptr_gray = 4'b0000;
    Rae_thresh = 4'd0;
    Rclr_err = 1'b0;
    tick(2);
    check_reset("rst");

    // single write crosses the synchroniser
    Rrst = 1'b0;
    Wptr_gray = 4'b0001;
    tick(2);
    check("lat2_empty", 32'(Rempty), 1);
    check("lat2_level", 32'(Rlevel), 0);
    tick(1);
    check("lat3_empty", 32'(Rempty), 0);
    check("lat3_level", 32'(Rlevel), 1);
    check("lat3_ae", 32'(Ralmost_empty), 0);

    // full FIFO then a read burst into underflow
    Wptr_gray = 4'b1100;
    Rae_thresh = 4'd2;
    tick(3);
    check("full_level", 32'(Rlevel), 8);
    check("full_ae", 32'(Ralmost_empty), 0);
    check("full_radder", 32'(Radder), 0);
    Rinc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i <= 8) begin
        check($sformatf("rd%0d_radder", i), 32'(Radder), i % 8);
        check($sformatf("rd%0d_rptr", i), 32'(Rptr), gexp[i]);
        check($sformatf("rd%0d_level", i), 32'(Rlevel), 8 - i);
        check($sformatf("rd%0d_ae", i), 32'(Ralmost_empty),
              (i >= 6) ? 1 : 0);
        check($sformatf("rd%0d_empty", i), 32'(Rempty),
              (i == 8) ? 1 : 0);
        check($sformatf("rd%0d_uf", i), 32'(Runderflow), 0);
      end else begin
        check($sformatf("rd%0d_rptr", i), 32'(Rptr), 12);
        check($sformatf("rd%0d_radder", i), 32'(Radder), 0);
        check($sformatf("rd%0d_level", i), 32'(Rlevel), 0);
        check($sformatf("rd%0d_uf", i), 32'(Runderflow), 1);
      end
    end
    Rinc = 1'b0;

    // walk the read pointer to bin 15, then wrap to 0
    Wptr_gray = 4'b1000;
    tick(3);
    check("pre_wrap_level", 32'(Rlevel), 7);
    Rinc = 1'b1;
    tick(7);
    Rinc = 1'b0;
    check("at15_rptr", 32'(Rptr), 8);
    check("at15_radder", 32'(Radder), 7);
    check("at15_empty", 32'(Rempty), 1);
    check("at15_level", 32'(Rlevel), 0);
    Wptr_gray = 4'b0000;
    tick(3);
    check("wrapw_level", 32'(Rlevel), 1);
    check("wrapw_empty", 32'(Rempty), 0);
    Rinc = 1'b1;
    tick(1);
    Rinc = 1'b0;
    check("wrap_rptr", 32'(Rptr), 0);
    check("wrap_radder", 32'(Radder), 0);
    check("wrap_empty", 32'(Rempty), 1);
    check("wrap_level", 32'(Rlevel), 0);

    // sticky error: clear alone, then set beats clear
    check("uf_before_clr", 32'(Runderflow), 1);
    Rclr_err = 1'b1;
    tick(1);
    check("uf_cleared", 32'(Runderflow), 0);
    Rinc = 1'b1;
    tick(1);
    check("uf_set_wins", 32'(Runderflow), 1);
    check("uf_rptr_hold", 32'(Rptr), 0);
    Rclr_err = 1'b0;
    Rinc = 1'b0;

    // threshold boundaries at level 5
    Wptr_gray = 4'b0111;
    tick(3);
    check("lvl5_level", 32'(Rlevel), 5);
    check("lvl5_ae_t2", 32'(Ralmost_empty), 0);
    Rae_thresh = 4'd8;
    tick(1);
    check("lvl5_ae_t8", 32'(Ralmost_empty), 1);
    Rae_thresh = 4'd5;
    tick(1);
    check("lvl5_ae_t5", 32'(Ralmost_empty), 1);
    Rae_thresh = 4'd4;
    tick(1);
    check("lvl5_ae_t4", 32'(Ralmost_empty), 0);

    // reset mid-burst discards the read and the synchroniser
    Rinc = 1'b1;
    Rrst = 1'b1;
    tick(1);
    check_reset("midrst");
    Rrst = 1'b0;
    Rinc = 1'b0;
    tick(2);
    check("reacq2_empty", 32'(Rempty), 1);
    check("reacq2_level", 32'(Rlevel), 0);
    tick(1);
    check("reacq3_level", 32'(Rlevel), 5);
    check("reacq3_empty", 32'(Rempty), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
